// File: rtl/pixel_pos_ctrl_pkg.sv
// rtl/pixel_pos_ctrl_pkg.sv - shared types and constants for the pixel position controller
package pixel_pos_ctrl_pkg;

  localparam int COORD_W = 13;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    LINE    = 2'd2,
    HBLANK  = 2'd3
  } state_t;

  typedef logic [2:0] rgn_t;

  localparam rgn_t RGN_RAW   = 3'd0;
  localparam rgn_t RGN_RED   = 3'd1;
  localparam rgn_t RGN_GREEN = 3'd2;
  localparam rgn_t RGN_BLUE  = 3'd3;
  localparam rgn_t RGN_BLACK = 3'd4;

  // Counters stick at the top code instead of wrapping back into the frame.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pixel_region_sel.sv
// rtl/pixel_region_sel.sv - combinational region code for a pixel position
module pixel_region_sel
  import pixel_pos_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = 617,
  parameter int V_ACTIVE = 478
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] mark,
  input  logic [COORD_W-1:0] h_lim,
  input  logic [COORD_W-1:0] v_lim,
  output rgn_t               sel
);

  localparam logic [COORD_W-1:0] H_ACT = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT = COORD_W'(V_ACTIVE);

  logic top_band;
  logic left_band;
  logic right_band;
  logic bottom_band;
  logic in_active;

  // Corner markers first, then active area, black for everything outside it.
  always_comb begin
    top_band    = (row < mark);
    left_band   = (col < mark);
    right_band  = (col >= h_lim) && (col < H_ACT);
    bottom_band = (row >= v_lim) && (row < V_ACT);
    in_active   = (row < V_ACT) && (col < H_ACT);
    if (top_band && left_band) begin
      sel = RGN_RED;
    end else if (top_band && right_band) begin
      sel = RGN_GREEN;
    end else if (bottom_band && left_band) begin
      sel = RGN_BLUE;
    end else if (in_active) begin
      sel = RGN_RAW;
    end else begin
      sel = RGN_BLACK;
    end
  end

endmodule

// File: rtl/pixel_pos_ctrl.sv
// rtl/pixel_pos_ctrl.sv - pixel row/col tracker with corner markers; PIXEL_POS_FRAME_CNT_EN adds oFRAME_CNT
module pixel_pos_ctrl
  import pixel_pos_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = 617,
  parameter int V_ACTIVE = 478,
  parameter int MARK_DEF = 5
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDE,
  input  logic               iVS,
  input  logic               iCFG_REQ,
  input  logic [3:0]         iCFG_MARK,
  output logic               oCFG_ACK,
  output logic [COORD_W-1:0] oROW,
  output logic [COORD_W-1:0] oCOL,
  output logic [2:0]         oSEL,
  output logic               oDE,
  output logic               oSOF
`ifdef PIXEL_POS_FRAME_CNT_EN
  ,
  output logic [15:0]        oFRAME_CNT
`endif
);

  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [3:0]         MARK_RST = 4'(MARK_DEF);
  localparam logic [COORD_W-1:0] MARK_EXT = {{(COORD_W-4){1'b0}}, MARK_RST};

  state_t             state_q, state_d;
  logic               vs_q, vs_d;
  logic               req_q, req_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [3:0]         mark_q, mark_d;
  logic [3:0]         pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [COORD_W-1:0] h_lim_q, h_lim_d;
  logic [COORD_W-1:0] v_lim_q, v_lim_d;
  logic [COORD_W-1:0] orow_q, orow_d;
  logic [COORD_W-1:0] ocol_q, ocol_d;
  rgn_t               osel_q, osel_d;
  logic               ode_q, ode_d;
  logic               osof_q, osof_d;
  logic               ack_q, ack_d;

  logic               vs_rise;
  logic               req_rise;
  logic               pix_vld;
  logic               pix_first;
  logic               vblank_entry;
  logic               apply;
  logic [COORD_W-1:0] pend_ext;
  rgn_t               rgn;

  // Frame/line state machine, counters and marker-size bookkeeping.
  always_comb begin
    vs_d       = iVS;
    req_d      = iCFG_REQ;
    vs_rise    = iVS & ~vs_q;
    req_rise   = iCFG_REQ & ~req_q;
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    mark_d     = mark_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    h_lim_d    = h_lim_q;
    v_lim_d    = v_lim_q;
    pix_vld    = 1'b0;
    pix_first  = 1'b0;
    pend_ext   = {{(COORD_W-4){1'b0}}, pend_q};

    case (state_q)
      WAIT_VS: begin
        if (vs_rise) state_d = VBLANK;
      end
      VBLANK: begin
        if (!vs_rise && iDE) begin
          state_d   = LINE;
          row_d     = '0;
          col_d     = '0;
          pix_vld   = 1'b1;
          pix_first = 1'b1;
        end
      end
      LINE: begin
        if (vs_rise) begin
          state_d = VBLANK;
        end else if (iDE) begin
          col_d   = sat_inc(col_q);
          pix_vld = 1'b1;
        end else begin
          state_d = HBLANK;
        end
      end
      HBLANK: begin
        if (vs_rise) begin
          state_d = VBLANK;
        end else if (iDE) begin
          state_d = LINE;
          row_d   = sat_inc(row_q);
          col_d   = '0;
          pix_vld = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase

    // Marker size only changes between frames; a request arriving on the
    // entry cycle itself waits for the following frame.
    vblank_entry = (state_d == VBLANK) && (state_q != VBLANK);
    apply        = vblank_entry && pend_vld_q;
    if (apply) begin
      mark_d     = pend_q;
      h_lim_d    = H_ACT - pend_ext;
      v_lim_d    = V_ACT - pend_ext;
      pend_vld_d = 1'b0;
    end
    if (req_rise) begin
      pend_vld_d = 1'b1;
      pend_d     = (iCFG_MARK == 4'd0) ? 4'd1 : iCFG_MARK;
    end
    ack_d = apply;
  end

  pixel_region_sel #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_region_sel (
    .row   (row_d),
    .col   (col_d),
    .mark  ({{(COORD_W-4){1'b0}}, mark_q}),
    .h_lim (h_lim_q),
    .v_lim (v_lim_q),
    .sel   (rgn)
  );

  // Output stage: position and region follow the sampled pixel, black when idle.
  always_comb begin
    ode_d  = pix_vld;
    osof_d = pix_first;
    orow_d = orow_q;
    ocol_d = ocol_q;
    osel_d = RGN_BLACK;
    if (pix_vld) begin
      orow_d = row_d;
      ocol_d = col_d;
      osel_d = rgn;
    end
  end

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= WAIT_VS;
      vs_q       <= 1'b0;
      req_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      mark_q     <= MARK_RST;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      h_lim_q    <= H_ACT - MARK_EXT;
      v_lim_q    <= V_ACT - MARK_EXT;
      orow_q     <= '0;
      ocol_q     <= '0;
      osel_q     <= RGN_BLACK;
      ode_q      <= 1'b0;
      osof_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      req_q      <= req_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mark_q     <= mark_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      h_lim_q    <= h_lim_d;
      v_lim_q    <= v_lim_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      osel_q     <= osel_d;
      ode_q      <= ode_d;
      osof_q     <= osof_d;
      ack_q      <= ack_d;
    end
  end

  assign oROW     = orow_q;
  assign oCOL     = ocol_q;
  assign oSEL     = osel_q;
  assign oDE      = ode_q;
  assign oSOF     = osof_q;
  assign oCFG_ACK = ack_q;

`ifdef PIXEL_POS_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Frame counter advances on every start-of-frame pulse, wrapping at 16 bits.
  always_comb begin
    fcnt_d = osof_q ? fcnt_q + 16'd1 : fcnt_q;
  end

  // Frame counter register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign oFRAME_CNT = fcnt_q;
`endif

endmodule

// File: tb/tb_pixel_pos_ctrl.sv
// tb/tb_pixel_pos_ctrl.sv - scoreboard bench for pixel_pos_ctrl
module tb_pixel_pos_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iDE;
  logic        iVS;
  logic        iCFG_REQ;
  logic [3:0]  iCFG_MARK;
  logic        oCFG_ACK;
  logic [12:0] oROW;
  logic [12:0] oCOL;
  logic [2:0]  oSEL;
  logic        oDE;
  logic        oSOF;
`ifdef PIXEL_POS_FRAME_CNT_EN
  logic [15:0] oFRAME_CNT;
`endif

  pixel_pos_ctrl #(
    .H_ACTIVE (617),
    .V_ACTIVE (478),
    .MARK_DEF (5)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDE        (iDE),
    .iVS        (iVS),
    .iCFG_REQ   (iCFG_REQ),
    .iCFG_MARK  (iCFG_MARK),
    .oCFG_ACK   (oCFG_ACK),
    .oROW       (oROW),
    .oCOL       (oCOL),
    .oSEL       (oSEL),
    .oDE        (oDE),
    .oSOF       (oSOF)
`ifdef PIXEL_POS_FRAME_CNT_EN
    ,
    .oFRAME_CNT (oFRAME_CNT)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int row;
    int col;
    int sel;
    int sof;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tb_m;
  int   tb_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sel_model(input int r, input int c, input int m);
    if (r < m && c < m) return 1;
    if (r < m && c >= 617 - m && c < 617) return 2;
    if (r >= 478 - m && r < 478 && c < m) return 3;
    if (r < 478 && c < 617) return 0;
    return 4;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_line(input int n, input int row, input bit push, input bit idle);
    for (int i = 0; i < n; i++) begin
      iDE = 1'b1;
      if (push) begin
        sb.push_back('{row, i, sel_model(row, i, tb_m), tb_first});
        tb_first = 0;
      end
      tick();
    end
    if (idle) begin
      iDE = 1'b0;
      tick();
    end
  endtask

  task automatic vs_pulse(input bit exp_ack, input bit req, input int mark);
    iDE = 1'b0;
    iVS = 1'b1;
    if (req) begin
      iCFG_REQ  = 1'b1;
      iCFG_MARK = 4'(mark);
    end
    tick();
    check("cfg_ack", 32'(oCFG_ACK), 32'(exp_ack));
    iVS      = 1'b0;
    iCFG_REQ = 1'b0;
    tick();
    check("cfg_ack_clear", 32'(oCFG_ACK), 0);
    tb_first = 1;
  endtask

  task automatic cfg_req(input int mark);
    iCFG_REQ  = 1'b1;
    iCFG_MARK = 4'(mark);
    tick();
    iCFG_REQ = 1'b0;
    tick();
    check("cfg_ack_midframe", 32'(oCFG_ACK), 0);
  endtask

  // Output monitor: every oDE beat must match the head of the scoreboard.
  always @(negedge iCLK) begin
    exp_t e;
    if (!iRST) begin
      if (oDE) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("row", 32'(oROW), e.row);
          check("col", 32'(oCOL), e.col);
          check("sel", 32'(oSEL), e.sel);
          check("sof", 32'(oSOF), e.sof);
        end
      end else begin
        check("idle_sel", 32'(oSEL), 4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRST      = 1'b1;
    iDE       = 1'b0;
    iVS       = 1'b0;
    iCFG_REQ  = 1'b0;
    iCFG_MARK = 4'd0;
    tb_m      = 5;
    tb_first  = 0;
    repeat (3) tick();
    check("rst_row", 32'(oROW), 0);
    check("rst_col", 32'(oCOL), 0);
    check("rst_sel", 32'(oSEL), 4);
    check("rst_de", 32'(oDE), 0);
    check("rst_sof", 32'(oSOF), 0);
    check("rst_ack", 32'(oCFG_ACK), 0);
`ifdef PIXEL_POS_FRAME_CNT_EN
    check("rst_fcnt", 32'(oFRAME_CNT), 0);
`endif
    iRST = 1'b0;
    tick();

    // iDE before any iVS edge is ignored
    drive_line(4, 0, 0, 1);

    // Frame 1: default marker; size change requested mid-frame
    vs_pulse(0, 0, 0);
    drive_line(617, 0, 1, 1);
    cfg_req(3);
    cfg_req(9);
    for (int r = 1; r < 477; r++) drive_line(1, r, 1, 1);
    drive_line(617, 477, 1, 1);
    repeat (2) tick();

    // Frame 2: new size 9, over-long line saturating into black
    vs_pulse(1, 0, 0);
    tb_m = 9;
    drive_line(700, 0, 1, 1);
    drive_line(3, 1, 1, 1);

    // Frame 3: request coincides with VBLANK entry, deferred a frame
    vs_pulse(0, 1, 0);
    drive_line(20, 0, 1, 1);

    // Frame 4: zero request becomes size 1
    vs_pulse(1, 0, 0);
    tb_m = 1;
    drive_line(3, 0, 1, 1);
    drive_line(2, 1, 1, 1);

    // Frame 5: reset while on row 200
    vs_pulse(0, 0, 0);
    for (int r = 0; r < 200; r++) drive_line(1, r, 1, 1);
    drive_line(5, 200, 1, 0);
    @(negedge iCLK);
    #2;
    iRST = 1'b1;
    #1;
    check("arst_row", 32'(oROW), 0);
    check("arst_col", 32'(oCOL), 0);
    check("arst_sel", 32'(oSEL), 4);
    check("arst_de", 32'(oDE), 0);
    check("arst_sof", 32'(oSOF), 0);
    check("arst_ack", 32'(oCFG_ACK), 0);
`ifdef PIXEL_POS_FRAME_CNT_EN
    check("arst_fcnt", 32'(oFRAME_CNT), 0);
`endif
    tick();
    tick();
    iRST = 1'b0;
    iDE  = 1'b0;
    tb_m = 5;
    tick();

    drive_line(5, 0, 0, 1);
    vs_pulse(0, 0, 0);
    drive_line(8, 0, 1, 1);
    drive_line(8, 1, 1, 1);
    vs_pulse(0, 0, 0);
    drive_line(8, 0, 1, 1);
    repeat (3) tick();
`ifdef PIXEL_POS_FRAME_CNT_EN
    check("fcnt_two_frames", 32'(oFRAME_CNT), 2);
`endif
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
